cache_line_fill_ctrl: RTL and testbench
=======================================

Name: cache_line_fill_ctrl

Overview:
- Miss-handling sequencer for the 4-way data cache.
- On a miss reported by the cache lookup logic, it writes the dirty victim line back to memory beat by beat, then refills the line beat by beat into the cache data SRAM, and signals completion.
- Sits between the cache tag/control logic, the cache SRAM array port and the single-outstanding memory bus.
- Owns only sequencing. Tag/valid/dirty update remains in the cache lookup logic and is triggered by `fill_done`.

Parameters:
- addrsize, 64, address width in bits.
- wordsize, 64, memory bus beat width in bits.
- logWidth, 7, log2 of line size in bytes (128-byte line).
- logDepth, 9, log2 of cache SRAM line entries (line index width).
- beats, (1<<logWidth)*8/wordsize = 16, beats per line (derived; must be a power of 2, ≥2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- miss_req  in  1  miss pending; held high by the cache until `fill_done`.
- miss_addr  in  addrsize  missing address (any byte offset).
- miss_line  in  logDepth  SRAM line entry {set, index} selected for the fill.
- victim_dirty  in  1  victim line must be written back.
- victim_addr  in  addrsize  victim line address (offset bits ignored).
- busy  out  1  controller not in IDLE.
- fill_done  out  1  one-cycle pulse: line fully refilled.
- arr_rd_en  out  1  SRAM beat read strobe.
- arr_we  out  1  SRAM beat write strobe.
- arr_line  out  logDepth  SRAM line entry addressed.
- arr_beat  out  $clog2(beats)  beat within line.
- arr_wdata  out  wordsize  fill beat data.
- arr_rdata  in  wordsize  victim beat data, valid the cycle after `arr_rd_en`.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  addrsize  beat byte address.
- mem_wdata  out  wordsize  write data.
- mem_ready  in  1  request accepted this cycle when `mem_req` = 1.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  wordsize  read data.
- proto_err  out  1  sticky: `mem_rvalid` seen with no read outstanding.

Behaviour:
- **Reset:** `reset_n` low forces state IDLE, beat counter 0, all outputs 0, captured registers 0, `proto_err` 0. Applies immediately, including mid-writeback or mid-fill. No `fill_done` is issued for an aborted operation.
- **Capture:** in IDLE, `miss_req` = 1 latches `miss_addr`, `miss_line`, `victim_addr` and `victim_dirty`, and clears the beat counter k.
  - Line base = address with the low logWidth bits zeroed.
  - Inputs are ignored after capture until return to IDLE.
- **States:** IDLE, WB_RD, WB_WR, FILL_REQ, FILL_WAIT, DONE.
- **IDLE:**
  - `miss_req` & `victim_dirty` → WB_RD.
  - `miss_req` & !`victim_dirty` → FILL_REQ.
  - Otherwise stay in IDLE.
- **WB_RD:** `arr_rd_en` = 1, `arr_line` = `miss_line`, `arr_beat` = k; next state WB_WR.
- **WB_WR:**
  - Drives `mem_req` = 1, `mem_we` = 1, `mem_addr` = victim_base + k*(wordsize/8).
  - `mem_wdata` = `arr_rdata` sampled on entry, held in a register.
  - `mem_req`/address/data stay stable until `mem_ready`.
  - On `mem_ready`: if k = beats-1, set k = 0 and go to FILL_REQ; else k++ and go to WB_RD.
- **FILL_REQ:**
  - Drives `mem_req` = 1, `mem_we` = 0, `mem_addr` = miss_base + k*(wordsize/8).
  - On `mem_ready` → FILL_WAIT.
- **FILL_WAIT:**
  - `mem_req` = 0.
  - On `mem_rvalid`: same cycle, `arr_we` = 1, `arr_line` = `miss_line`, `arr_beat` = k, `arr_wdata` = `mem_rdata`.
  - Then if k = beats-1 → DONE; else k++ → FILL_REQ.
- **DONE:** `fill_done` = 1 for exactly one cycle; next state IDLE. `busy` = 0 in the following cycle.
  - A `miss_req` still high in that IDLE cycle is treated as a new miss; the cache must drop it in the DONE cycle.
- **Ordering:** beats are always in ascending order from beat 0; no critical-word-first.
- **Outstanding requests:** one memory request at a time.
  - `mem_rvalid` is sampled only in FILL_WAIT.
  - In any other state it sets `proto_err` and its data is discarded.
  - `mem_rvalid` in the same cycle `mem_ready` accepts the read (i.e. in FILL_REQ) is a protocol error; memory must return data ≥1 cycle later.
- **Minimum latency** (`mem_ready` and `mem_rvalid` at the earliest cycle):
  - Clean fill = 2*beats + 1 cycles from capture edge to `fill_done` = 33.
  - Dirty = 4*beats + 1 = 65.
- **Address arithmetic:** modulo 2^addrsize. A base at top of address space wraps; no carry out.

Test Plan:
- **Clean miss:** `miss_addr` = 0x0000_0000_1000_0047, `miss_line` = 0x05A, `mem_ready`/`mem_rvalid` immediate, `mem_rdata` = beat index → 16 reads at 0x1000_0000..0x1000_0078 step 8, 16 `arr_we` on line 0x05A with beats 0..15 and data 0..15, `fill_done` pulse 33 cycles after capture, no writes.
- **Dirty miss:** `victim_addr` = 0x2000_0080, `arr_rdata` = 0xA0+beat → 16 writes at 0x2000_0080..0x2000_00F8 with data 0xA0..0xAF before the first read; `fill_done` at cycle 65.
- **Backpressure:** `mem_ready` low for 3 cycles on each request, `mem_rvalid` delayed 2 cycles → `mem_req`/`mem_addr`/`mem_wdata` stable while waiting, beat order unchanged, `fill_done` once.
- **Reset mid-fill:** assert `reset_n` = 0 at beat 7 of fill → all outputs 0 immediately, no `fill_done`; a new miss after release restarts at beat 0.
- **Spurious data:** `mem_rvalid` pulsed in IDLE → `proto_err` = 1 and stays set, no `arr_we`; cleared only by reset.
- **Back-to-back:** `miss_req` re-asserted with a new address the cycle after DONE → second capture in that IDLE cycle, correct second line filled.

Source files
------------

// File: rtl/cache_line_fill_ctrl.sv
// Miss sequencer for the 4-way data cache: writes back a dirty victim line
// beat by beat, then refills the missing line beat by beat into the SRAM.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for miss_req; captures miss/victim info
// WB_RD      | read victim beat k from the SRAM
// WB_WR      | write victim beat k to memory, wait for mem_ready
// FILL_REQ   | issue read of miss beat k, wait for mem_ready
// FILL_WAIT  | wait for mem_rvalid, write beat k into the SRAM
// DONE       | one-cycle fill_done pulse
module cache_line_fill_ctrl #(
    parameter int addrsize = 64,
    parameter int wordsize = 64,
    parameter int logWidth = 7,
    parameter int logDepth = 9,
    localparam int beats   = (1 << logWidth) * 8 / wordsize
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      miss_req,
    input  logic [addrsize-1:0]       miss_addr,
    input  logic [logDepth-1:0]       miss_line,
    input  logic                      victim_dirty,
    input  logic [addrsize-1:0]       victim_addr,
    output logic                      busy,
    output logic                      fill_done,
    output logic                      arr_rd_en,
    output logic                      arr_we,
    output logic [logDepth-1:0]       arr_line,
    output logic [$clog2(beats)-1:0]  arr_beat,
    output logic [wordsize-1:0]       arr_wdata,
    input  logic [wordsize-1:0]       arr_rdata,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [addrsize-1:0]       mem_addr,
    output logic [wordsize-1:0]       mem_wdata,
    input  logic                      mem_ready,
    input  logic                      mem_rvalid,
    input  logic [wordsize-1:0]       mem_rdata,
    output logic                      proto_err
);

    localparam int kw  = $clog2(beats);
    localparam int bsh = $clog2(wordsize / 8);
    localparam logic [kw-1:0]       k_last    = kw'(beats - 1);
    localparam logic [addrsize-1:0] base_mask = ~addrsize'((1 << logWidth) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_RD,
        S_WB_WR,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [kw-1:0]         r_k;
    logic [addrsize-1:0]   r_miss_base;
    logic [addrsize-1:0]   r_victim_base;
    logic [logDepth-1:0]   r_line;
    logic [wordsize-1:0]   r_wdata;
    logic                  r_wb_first;
    logic                  r_proto_err;
    logic [addrsize-1:0]   w_off;

    assign w_off     = {{(addrsize - kw){1'b0}}, r_k} << bsh;
    assign proto_err = r_proto_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k           <= '0;
            r_miss_base   <= '0;
            r_victim_base <= '0;
            r_line        <= '0;
            r_wdata       <= '0;
            r_wb_first    <= 1'b0;
            r_proto_err   <= 1'b0;
        end else begin
            // SRAM read data is only valid in the first WB_WR cycle; hold it
            // for as long as memory keeps the write waiting.
            r_wb_first <= (r_state == S_WB_RD);
            if (r_wb_first) begin
                r_wdata <= arr_rdata;
            end
            if (mem_rvalid && (r_state != S_FILL_WAIT)) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (miss_req) begin
                        r_miss_base   <= miss_addr & base_mask;
                        r_victim_base <= victim_addr & base_mask;
                        r_line        <= miss_line;
                        r_k           <= '0;
                    end
                end
                S_WB_WR: begin
                    if (mem_ready) begin
                        r_k <= r_k + kw'(1);
                    end
                end
                S_FILL_WAIT: begin
                    if (mem_rvalid && (r_k != k_last)) begin
                        r_k <= r_k + kw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = (r_state != S_IDLE);
        fill_done = 1'b0;
        arr_rd_en = 1'b0;
        arr_we    = 1'b0;
        arr_line  = '0;
        arr_beat  = '0;
        arr_wdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (miss_req) begin
                    w_next = victim_dirty ? S_WB_RD : S_FILL_REQ;
                end
            end
            S_WB_RD: begin
                arr_rd_en = 1'b1;
                arr_line  = r_line;
                arr_beat  = r_k;
                w_next    = S_WB_WR;
            end
            S_WB_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_victim_base + w_off;
                mem_wdata = r_wb_first ? arr_rdata : r_wdata;
                if (mem_ready) begin
                    w_next = (r_k == k_last) ? S_FILL_REQ : S_WB_RD;
                end
            end
            S_FILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = r_miss_base + w_off;
                if (mem_ready) begin
                    w_next = S_FILL_WAIT;
                end
            end
            S_FILL_WAIT: begin
                if (mem_rvalid) begin
                    arr_we    = 1'b1;
                    arr_line  = r_line;
                    arr_beat  = r_k;
                    arr_wdata = mem_rdata;
                    w_next    = (r_k == k_last) ? S_DONE : S_FILL_REQ;
                end
            end
            S_DONE: begin
                fill_done = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Bench for cache_line_fill_ctrl: memory/SRAM responder, ordered scoreboards
// for memory requests and SRAM writes, and one task per scenario.
module tb_cache_line_fill_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         miss_req;
    logic [63:0]  miss_addr;
    logic [8:0]   miss_line;
    logic         victim_dirty;
    logic [63:0]  victim_addr;
    logic         busy;
    logic         fill_done;
    logic         arr_rd_en;
    logic         arr_we;
    logic [8:0]   arr_line;
    logic [3:0]   arr_beat;
    logic [63:0]  arr_wdata;
    logic [63:0]  arr_rdata;
    logic         mem_req;
    logic         mem_we;
    logic [63:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic         mem_ready;
    logic         mem_rvalid;
    logic [63:0]  mem_rdata;
    logic         proto_err;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           ready_dly = 0;
    int           rv_dly    = 0;
    logic [63:0]  tag       = 64'h0;
    logic         force_rv  = 1'b0;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] data;
    } mem_t;
    typedef struct packed {
        logic [8:0]  line;
        logic [3:0]  beat;
        logic [63:0] data;
    } arr_t;

    mem_t mem_q[$];
    arr_t arr_q[$];

    always #5 clk = ~clk;

    cache_line_fill_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .miss_line    (miss_line),
        .victim_dirty (victim_dirty),
        .victim_addr  (victim_addr),
        .busy         (busy),
        .fill_done    (fill_done),
        .arr_rd_en    (arr_rd_en),
        .arr_we       (arr_we),
        .arr_line     (arr_line),
        .arr_beat     (arr_beat),
        .arr_wdata    (arr_wdata),
        .arr_rdata    (arr_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .proto_err    (proto_err)
    );

    // Memory and SRAM responder; SRAM read data appears the cycle after
    // arr_rd_en and is garbage otherwise, so the write data must be held.
    initial begin
        logic        pend;
        int          rcnt;
        int          wcnt;
        logic [63:0] rdat;
        logic        prev_rd;
        logic [3:0]  prev_beat;
        pend = 1'b0; rcnt = 0; wcnt = 0; rdat = '0;
        prev_rd = 1'b0; prev_beat = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; arr_rdata = '0;
        forever begin
            @(posedge clk); #1;
            arr_rdata  = prev_rd ? (64'hA0 + 64'(prev_beat)) : 64'hDEAD_BEEF;
            mem_rvalid = 1'b0;
            mem_ready  = 1'b0;
            if (reset_n !== 1'b1) begin
                pend = 1'b0;
                wcnt = 0;
            end else begin
                if (pend) begin
                    if (rcnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rdat;
                        pend       = 1'b0;
                    end else begin
                        rcnt--;
                    end
                end
                if (force_rv) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 64'h5A5A_5A5A;
                    force_rv   = 1'b0;
                end
                if (mem_req === 1'b1) begin
                    if (wcnt < ready_dly) begin
                        wcnt++;
                    end else begin
                        mem_ready = 1'b1;
                        wcnt      = 0;
                        if (mem_we === 1'b0) begin
                            pend = 1'b1;
                            rcnt = rv_dly;
                            rdat = tag + 64'(mem_addr[6:3]);
                        end
                    end
                end
            end
            @(negedge clk);
            prev_rd   = arr_rd_en;
            prev_beat = arr_beat;
        end
    end

    // Scoreboard: in-order memory requests, SRAM fill writes, stall stability.
    initial begin
        logic        pw;
        logic        pwe;
        logic [63:0] paddr;
        logic [63:0] pdata;
        mem_t        em;
        arr_t        ea;
        pw = 1'b0; pwe = 1'b0; paddr = '0; pdata = '0;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                pw = 1'b0;
            end else begin
                if (pw) begin
                    n_checks++;
                    if (mem_req !== 1'b1 || mem_we !== pwe || mem_addr !== paddr || mem_wdata !== pdata) begin
                        n_fail++;
                        $display("FAIL mem_stable: got req=%b we=%b addr=%h wdata=%h, required req=1 we=%b addr=%h wdata=%h",
                                 mem_req, mem_we, mem_addr, mem_wdata, pwe, paddr, pdata);
                    end
                end
                if (mem_req === 1'b1 && mem_ready === 1'b1) begin
                    n_checks++;
                    if (mem_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL mem_unexpected: got we=%b addr=%h, required no request", mem_we, mem_addr);
                    end else begin
                        em = mem_q.pop_front();
                        if (mem_we !== em.we || mem_addr !== em.addr || (em.we && mem_wdata !== em.data)) begin
                            n_fail++;
                            $display("FAIL mem_req: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                     mem_we, mem_addr, mem_wdata, em.we, em.addr, em.data);
                        end
                    end
                end
                pw    = (mem_req === 1'b1) && (mem_ready !== 1'b1);
                pwe   = mem_we;
                paddr = mem_addr;
                pdata = mem_wdata;
                if (arr_we !== 1'b0) begin
                    n_checks++;
                    if (arr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL arr_unexpected: got we=%b line=%h beat=%0d, required no write", arr_we, arr_line, arr_beat);
                    end else begin
                        ea = arr_q.pop_front();
                        if (arr_line !== ea.line || arr_beat !== ea.beat || arr_wdata !== ea.data) begin
                            n_fail++;
                            $display("FAIL arr_write: got line=%h beat=%0d data=%h, required line=%h beat=%0d data=%h",
                                     arr_line, arr_beat, arr_wdata, ea.line, ea.beat, ea.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_fill(input logic [63:0] base, input logic [8:0] line, input logic [63:0] t);
        mem_t m;
        arr_t a;
        for (int b = 0; b < 16; b++) begin
            m.we = 1'b0; m.addr = base + 64'(b * 8); m.data = '0;
            mem_q.push_back(m);
            a.line = line; a.beat = 4'(b); a.data = t + 64'(b);
            arr_q.push_back(a);
        end
    endtask

    task automatic push_wb(input logic [63:0] vbase);
        mem_t m;
        for (int b = 0; b < 16; b++) begin
            m.we = 1'b1; m.addr = vbase + 64'(b * 8); m.data = 64'hA0 + 64'(b);
            mem_q.push_back(m);
        end
    endtask

    task automatic drive_miss(input logic [63:0] a, input logic [8:0] l, input logic [63:0] va, input logic d);
        miss_addr = a; miss_line = l; victim_addr = va; victim_dirty = d; miss_req = 1'b1;
    endtask

    // Called just after the edge where miss_req was raised; the first negedge
    // is the capture cycle, so the returned latency counts from it.
    task automatic wait_fill(input string nm, input int exp_lat, input int budget);
        int cyc;
        bit seen;
        cyc = 0; seen = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            if (fill_done === 1'b1) seen = 1;
            else cyc++;
        end
        miss_req = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: got no fill_done in %0d cycles, required fill_done", nm, budget);
        end else if (exp_lat >= 0 && cyc != exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", nm, cyc, exp_lat);
        end
    endtask

    task automatic settle(input string nm);
        int extra;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (fill_done !== 1'b0) extra++;
        end
        n_checks++;
        if (extra != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: got extra_done=%0d busy=%b, required 0 and 0", nm, extra, busy);
        end
        n_checks++;
        if (mem_q.size() != 0 || arr_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_left: got %0d mem and %0d arr pending, required 0 and 0", nm, mem_q.size(), arr_q.size());
        end
    endtask

    task automatic test_reset;
        logic [7+9+4+192-1:0] v;
        reset_n = 1'b0; miss_req = 1'b0; miss_addr = '0; miss_line = '0;
        victim_dirty = 1'b0; victim_addr = '0;
        repeat (3) @(negedge clk);
        v = {busy, fill_done, arr_rd_en, arr_we, mem_req, mem_we, proto_err,
             arr_line, arr_beat, arr_wdata, mem_addr, mem_wdata};
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", v);
        end
        #2 reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b proto_err=%b, required 0 0", busy, proto_err);
        end
    endtask

    task automatic test_clean_miss;
        @(posedge clk); #1;
        ready_dly = 0; rv_dly = 0; tag = 64'h0;
        push_fill(64'h1000_0000, 9'h05A, 64'h0);
        drive_miss(64'h1000_0047, 9'h05A, 64'h2000_0080, 1'b0);
        wait_fill("clean", 33, 100);
        settle("clean");
    endtask

    task automatic test_dirty_miss;
        @(posedge clk); #1;
        tag = 64'h100;
        push_wb(64'h2000_0080);
        push_fill(64'h3000_0180, 9'h1C3, 64'h100);
        drive_miss(64'h3000_01C5, 9'h1C3, 64'h2000_00B3, 1'b1);
        wait_fill("dirty", 65, 150);
        settle("dirty");
    endtask

    task automatic test_backpressure;
        @(posedge clk); #1;
        ready_dly = 3; rv_dly = 2; tag = 64'h500;
        push_wb(64'h2000_0100);
        push_fill(64'h8000_0000, 9'h0F0, 64'h500);
        drive_miss(64'h8000_0020, 9'h0F0, 64'h2000_0100, 1'b1);
        wait_fill("backpressure", -1, 600);
        settle("backpressure");
        ready_dly = 0; rv_dly = 0;
    endtask

    task automatic test_reset_mid_fill;
        logic [7+9+4+192-1:0] v;
        int cyc;
        bit found;
        @(posedge clk); #1;
        tag = 64'h600;
        push_fill(64'h4000_0000, 9'h011, 64'h600);
        drive_miss(64'h4000_0000, 9'h011, 64'h0, 1'b0);
        cyc = 0; found = 0;
        while (!found && cyc < 100) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 64'h4000_0038) found = 1;
            else cyc++;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL midfill_beat7: got no beat 7 request, required request at %h", 64'h4000_0038);
        end
        #2 reset_n = 1'b0;
        miss_req = 1'b0;
        #1;
        v = {busy, fill_done, arr_rd_en, arr_we, mem_req, mem_we, proto_err,
             arr_line, arr_beat, arr_wdata, mem_addr, mem_wdata};
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL midfill_reset: got %h, required 0", v);
        end
        mem_q.delete();
        arr_q.delete();
        repeat (2) @(negedge clk);
        n_checks++;
        if (fill_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midfill_abort: got fill_done=%b busy=%b, required 0 0", fill_done, busy);
        end
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        tag = 64'h200;
        push_fill(64'h5000_0000, 9'h022, 64'h200);
        drive_miss(64'h5000_0010, 9'h022, 64'h0, 1'b0);
        wait_fill("restart", 33, 100);
        settle("restart");
    endtask

    task automatic test_spurious;
        @(posedge clk); #1;
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_pre: got proto_err=%b, required 0", proto_err);
        end
        @(negedge clk);
        force_rv = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_rvalid !== 1'b1 || arr_we !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_pulse: got rvalid=%b arr_we=%b, required 1 0", mem_rvalid, arr_we);
        end
        @(negedge clk);
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_set: got proto_err=%b, required 1", proto_err);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_sticky: got proto_err=%b, required 1", proto_err);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_clear: got proto_err=%b, required 0", proto_err);
        end
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        tag = 64'h300;
        push_fill(64'h6000_0000, 9'h033, 64'h300);
        drive_miss(64'h6000_0008, 9'h033, 64'h0, 1'b0);
        wait_fill("b2b_first", 33, 100);
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy: got busy=%b after done, required 0", busy);
        end
        tag = 64'h400;
        push_fill(64'hFFFF_FFFF_FFFF_FF80, 9'h1FF, 64'h400);
        drive_miss(64'hFFFF_FFFF_FFFF_FFC1, 9'h1FF, 64'h0, 1'b0);
        wait_fill("b2b_second", 33, 100);
        settle("b2b");
    endtask

    initial begin
        test_reset;
        test_clean_miss;
        test_dirty_miss;
        test_backpressure;
        test_reset_mid_fill;
        test_spurious;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
